sal_sched: RTL and testbench
============================

SAL_SCHED -- requirements
Module: SAL_SCHED

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: number of SAL_BK_CTRL instances arbitrated (power of two, 2..8).
REQ-002 SHALL have parameter RA_WIDTH, default 14: row address width; CA_WIDTH, default 10: column address width; ADDR_WIDTH, default 14: DRAM address bus width (>= RA_WIDTH, >= 11).
REQ-003 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock, reset synchronous and active-low.
REQ-004 SHALL have ports act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i (in, NUM_BANKS each): per-bank command requests.
REQ-005 SHALL have ports ra_i (in, NUM_BANKS*RA_WIDTH) and ca_i (in, NUM_BANKS*CA_WIDTH): per-bank row/column addresses, bank b at slice b.
REQ-006 SHALL have ports act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o (out, NUM_BANKS each): per-bank grants.
REQ-007 SHALL have ports t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i (in, 4 each): inter-bank timing in clk cycles.
REQ-008 SHALL have ports cs_n_o, ras_n_o, cas_n_o, we_n_o (out, 1 each), ba_o (out, log2(NUM_BANKS)), addr_o (out, ADDR_WIDTH): registered DDR2 command bus.

Function
REQ-009 SHALL assert at most one bit across all five grant vectors per cycle.
REQ-010 Grants SHALL be combinational from requests, counters and pointer in the same cycle (zero latency).
REQ-011 Class priority SHALL be RD/WR > PRE > ACT > REF; the highest class with an eligible request wins.
REQ-012 Within a class, selection SHALL be round-robin from pointer rr_ptr; on any grant rr_ptr <= (granted bank + 1) mod NUM_BANKS.
REQ-013 If one bank asserts several requests, only its highest-priority one (RD > WR > PRE > ACT > REF) is eligible.
REQ-014 Counters cnt_rrd, cnt_ccd, cnt_wtr, cnt_rtw SHALL decrement by 1 per cycle, saturating at 0.
REQ-015 An ACT grant SHALL load cnt_rrd with t_rrd_i; ACT eligible only when cnt_rrd == 0.
REQ-016 An RD or WR grant SHALL load cnt_ccd with t_ccd_i; RD/WR eligible only when cnt_ccd == 0.
REQ-017 A WR grant SHALL load cnt_wtr with t_wtr_i; RD eligible only when cnt_wtr == 0.
REQ-018 An RD grant SHALL load cnt_rtw with t_rtw_i; WR eligible only when cnt_rtw == 0.
REQ-019 A loaded value of t means the next blocked command issues no earlier than t cycles after the grant; t = 0 or 1 imposes no extra delay.
REQ-020 Grant in cycle n SHALL drive the command bus in cycle n+1: cs_n=0, ba_o = granted bank.
REQ-021 Encodings (ras_n,cas_n,we_n): ACT 0,1,1 addr=ra zero-extended; RD 1,0,1 addr=ca with A10=0; WR 1,0,0 addr=ca with A10=0; PRE 0,1,0 A10=0; REF 0,0,1 addr=0.
REQ-022 Cycle without grant SHALL drive NOP: cs_n=0, ras_n=cas_n=we_n=1, ba_o and addr_o hold previous values.
REQ-023 Request deasserted without grant SHALL be dropped with no state change; requests are not latched.

Reset
REQ-024 While rst_n = 0 at a clk edge: cs_n_o=ras_n_o=cas_n_o=we_n_o=1, ba_o=0, addr_o=0, all counters 0, rr_ptr=0.
REQ-025 While rst_n = 0, all grant outputs SHALL be 0 regardless of requests; reset mid-burst aborts pending timing windows.

Configuration
REQ-026 With macro SAL_SCHED_STATS_EN defined, SHALL add outputs rd_cnt_o, wr_cnt_o, act_cnt_o (out, 32 each), incremented on each RD/WR/ACT grant, wrapping at 2^32, reset to 0.
REQ-027 Without SAL_SCHED_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-028 Bank0 and bank2 assert act_req, t_rrd=4, rr_ptr=0 -> bank0 ACT cycle 0, bank2 ACT cycle 4; bus shows ACT ba=0 in cycle 1, ba=2 in cycle 5.
REQ-029 Bank1 wr_req granted, then bank3 rd_req held, t_wtr=6, t_ccd=2 -> bank3 rd_gnt exactly 6 cycles after WR grant.
REQ-030 Same cycle: bank0 rd_req, bank1 pre_req, bank2 act_req, bank3 ref_req -> only rd_gnt_o=4'b0001; next cycles PRE b1, ACT b2, REF b3.
REQ-031 All four banks hold rd_req, t_ccd=1 -> grants to banks 0,1,2,3,0 on consecutive cycles.
REQ-032 rst_n low for one cycle 2 cycles after ACT with t_rrd=8 -> counters cleared; pending ACT granted the cycle after rst_n returns high.
REQ-033 With SAL_SCHED_STATS_EN: 3 RD and 2 WR grants -> rd_cnt_o=3, wr_cnt_o=2, act_cnt_o=0.

Source files
------------

// File: rtl/sal_sched.sv
// SAL_SCHED: arbitrates per-bank command requests from several bank controllers onto one
// registered DDR2 command bus. It enforces the inter-bank tRRD/tCCD/tWTR/tRTW spacing and
// selects banks round-robin within each command class.
// Optional feature: define SAL_SCHED_STATS_EN to add the RD/WR/ACT grant counters.
module sal_sched #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned RA_WIDTH   = 14,
    parameter int unsigned CA_WIDTH   = 10,
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_BANKS-1:0]            act_req_i,
    input  logic [NUM_BANKS-1:0]            rd_req_i,
    input  logic [NUM_BANKS-1:0]            wr_req_i,
    input  logic [NUM_BANKS-1:0]            pre_req_i,
    input  logic [NUM_BANKS-1:0]            ref_req_i,
    input  logic [NUM_BANKS*RA_WIDTH-1:0]   ra_i,
    input  logic [NUM_BANKS*CA_WIDTH-1:0]   ca_i,
    output logic [NUM_BANKS-1:0]            act_gnt_o,
    output logic [NUM_BANKS-1:0]            rd_gnt_o,
    output logic [NUM_BANKS-1:0]            wr_gnt_o,
    output logic [NUM_BANKS-1:0]            pre_gnt_o,
    output logic [NUM_BANKS-1:0]            ref_gnt_o,
    input  logic [3:0]                      t_rrd_i,
    input  logic [3:0]                      t_ccd_i,
    input  logic [3:0]                      t_wtr_i,
    input  logic [3:0]                      t_rtw_i,
    output logic                            cs_n_o,
    output logic                            ras_n_o,
    output logic                            cas_n_o,
    output logic                            we_n_o,
    output logic [$clog2(NUM_BANKS)-1:0]    ba_o,
    output logic [ADDR_WIDTH-1:0]           addr_o
`ifdef SAL_SCHED_STATS_EN
    ,
    output logic [31:0]                     rd_cnt_o,
    output logic [31:0]                     wr_cnt_o,
    output logic [31:0]                     act_cnt_o
`endif
);

    localparam int unsigned BA_WIDTH = $clog2(NUM_BANKS);

    typedef enum logic [2:0] {CmdNone, CmdRd, CmdWr, CmdPre, CmdAct, CmdRef} cmd_e;

    logic [3:0]           cnt_rrd_q, cnt_ccd_q, cnt_wtr_q, cnt_rtw_q;
    logic [BA_WIDTH-1:0]  rr_ptr_q;
    logic [NUM_BANKS-1:0] rd_elig, wr_elig, pre_elig, act_elig, ref_elig, cand;
    logic [BA_WIDTH-1:0]  idx, sel_bank;
    logic                 gnt_valid;
    cmd_e                 sel_cmd;
    logic [RA_WIDTH-1:0]  ra_sel;
    logic [CA_WIDTH-1:0]  ca_sel;
    logic [ADDR_WIDTH-1:0] ra_ext, ca_ext;

    // A loaded value t lets the blocked command go exactly t cycles after the grant.
    function automatic logic [3:0] sat_dec(input logic [3:0] c);
        return (c == 4'd0) ? 4'd0 : c - 4'd1;
    endfunction

    // Each bank offers only its own top request; that request then passes or fails timing.
    always_comb begin
        rd_elig  = '0;
        wr_elig  = '0;
        pre_elig = '0;
        act_elig = '0;
        ref_elig = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_req_i[b])       rd_elig[b]  = (cnt_ccd_q == 4'd0) && (cnt_wtr_q == 4'd0);
            else if (wr_req_i[b])  wr_elig[b]  = (cnt_ccd_q == 4'd0) && (cnt_rtw_q == 4'd0);
            else if (pre_req_i[b]) pre_elig[b] = 1'b1;
            else if (act_req_i[b]) act_elig[b] = (cnt_rrd_q == 4'd0);
            else if (ref_req_i[b]) ref_elig[b] = 1'b1;
        end
    end

    // Pick the highest non-empty class, then the first candidate at or after rr_ptr.
    always_comb begin
        cand = '0;
        if (|(rd_elig | wr_elig)) cand = rd_elig | wr_elig;
        else if (|pre_elig)       cand = pre_elig;
        else if (|act_elig)       cand = act_elig;
        else                      cand = ref_elig;
        gnt_valid = 1'b0;
        sel_bank  = '0;
        idx       = '0;
        // Walk offsets downwards so the smallest offset from the pointer wins.
        for (int off = NUM_BANKS - 1; off >= 0; off--) begin
            idx = rr_ptr_q + BA_WIDTH'(off);
            if (cand[idx]) begin
                gnt_valid = 1'b1;
                sel_bank  = idx;
            end
        end
    end

    // Decode the winner into a single grant bit; reset masks every grant.
    always_comb begin
        act_gnt_o = '0;
        rd_gnt_o  = '0;
        wr_gnt_o  = '0;
        pre_gnt_o = '0;
        ref_gnt_o = '0;
        sel_cmd   = CmdNone;
        if (rst_n && gnt_valid) begin
            if (rd_elig[sel_bank]) begin
                rd_gnt_o[sel_bank] = 1'b1;
                sel_cmd = CmdRd;
            end else if (wr_elig[sel_bank]) begin
                wr_gnt_o[sel_bank] = 1'b1;
                sel_cmd = CmdWr;
            end else if (pre_elig[sel_bank]) begin
                pre_gnt_o[sel_bank] = 1'b1;
                sel_cmd = CmdPre;
            end else if (act_elig[sel_bank]) begin
                act_gnt_o[sel_bank] = 1'b1;
                sel_cmd = CmdAct;
            end else begin
                ref_gnt_o[sel_bank] = 1'b1;
                sel_cmd = CmdRef;
            end
        end
    end

    // Address of the selected bank; column addresses keep A10 (auto-precharge) low.
    always_comb begin
        ra_sel = ra_i[int'(sel_bank)*RA_WIDTH +: RA_WIDTH];
        ca_sel = ca_i[int'(sel_bank)*CA_WIDTH +: CA_WIDTH];
        ra_ext = ADDR_WIDTH'(ra_sel);
        ca_ext = ADDR_WIDTH'(ca_sel);
        ca_ext[10] = 1'b0;
    end

    // Timing counters, round-robin pointer and the registered command bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_rrd_q <= 4'd0;
            cnt_ccd_q <= 4'd0;
            cnt_wtr_q <= 4'd0;
            cnt_rtw_q <= 4'd0;
            rr_ptr_q  <= '0;
            cs_n_o    <= 1'b1;
            ras_n_o   <= 1'b1;
            cas_n_o   <= 1'b1;
            we_n_o    <= 1'b1;
            ba_o      <= '0;
            addr_o    <= '0;
        end else begin
            cnt_rrd_q <= (sel_cmd == CmdAct) ? sat_dec(t_rrd_i) : sat_dec(cnt_rrd_q);
            cnt_ccd_q <= (sel_cmd == CmdRd || sel_cmd == CmdWr) ? sat_dec(t_ccd_i)
                                                                : sat_dec(cnt_ccd_q);
            cnt_wtr_q <= (sel_cmd == CmdWr) ? sat_dec(t_wtr_i) : sat_dec(cnt_wtr_q);
            cnt_rtw_q <= (sel_cmd == CmdRd) ? sat_dec(t_rtw_i) : sat_dec(cnt_rtw_q);
            if (sel_cmd != CmdNone) begin
                rr_ptr_q <= sel_bank + BA_WIDTH'(1);
                ba_o     <= sel_bank;
            end
            cs_n_o <= 1'b0;
            unique case (sel_cmd)
                CmdAct: begin
                    {ras_n_o, cas_n_o, we_n_o} <= 3'b011;
                    addr_o <= ra_ext;
                end
                CmdRd: begin
                    {ras_n_o, cas_n_o, we_n_o} <= 3'b101;
                    addr_o <= ca_ext;
                end
                CmdWr: begin
                    {ras_n_o, cas_n_o, we_n_o} <= 3'b100;
                    addr_o <= ca_ext;
                end
                CmdPre: begin
                    {ras_n_o, cas_n_o, we_n_o} <= 3'b010;
                    addr_o <= '0;
                end
                CmdRef: begin
                    {ras_n_o, cas_n_o, we_n_o} <= 3'b001;
                    addr_o <= '0;
                end
                default: {ras_n_o, cas_n_o, we_n_o} <= 3'b111;
            endcase
        end
    end

`ifdef SAL_SCHED_STATS_EN
    // Free-running grant statistics, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_o  <= 32'd0;
            wr_cnt_o  <= 32'd0;
            act_cnt_o <= 32'd0;
        end else begin
            if (sel_cmd == CmdRd)  rd_cnt_o  <= rd_cnt_o + 32'd1;
            if (sel_cmd == CmdWr)  wr_cnt_o  <= wr_cnt_o + 32'd1;
            if (sel_cmd == CmdAct) act_cnt_o <= act_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sal_sched.sv
// Self-checking bench for sal_sched: table of per-cycle requests and expected grants,
// plus hand sequences for timing windows and mid-run reset. The expected command bus is
// pushed to a scoreboard on each cycle and compared one cycle later.
module tb_sal_sched;

    localparam int NB  = 4;
    localparam int RAW = 14;
    localparam int CAW = 10;
    localparam int AW  = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NB-1:0] act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i;
    logic [NB*RAW-1:0] ra_i;
    logic [NB*CAW-1:0] ca_i;
    logic [NB-1:0] act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o;
    logic [3:0] t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i;
    logic cs_n_o, ras_n_o, cas_n_o, we_n_o;
    logic [1:0] ba_o;
    logic [AW-1:0] addr_o;
`ifdef SAL_SCHED_STATS_EN
    logic [31:0] rd_cnt_o, wr_cnt_o, act_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] act, rd, wr, pre, rf;
        logic [3:0] e_act, e_rd, e_wr, e_pre, e_rf;
    } vec_t;

    vec_t tbl[17];
    logic [19:0] sb[$];
    logic [1:0] m_ba = 2'd0;
    logic [AW-1:0] m_addr = '0;

    sal_sched dut (
        .clk(clk), .rst_n(rst_n),
        .act_req_i(act_req_i), .rd_req_i(rd_req_i), .wr_req_i(wr_req_i),
        .pre_req_i(pre_req_i), .ref_req_i(ref_req_i),
        .ra_i(ra_i), .ca_i(ca_i),
        .act_gnt_o(act_gnt_o), .rd_gnt_o(rd_gnt_o), .wr_gnt_o(wr_gnt_o),
        .pre_gnt_o(pre_gnt_o), .ref_gnt_o(ref_gnt_o),
        .t_rrd_i(t_rrd_i), .t_ccd_i(t_ccd_i), .t_wtr_i(t_wtr_i), .t_rtw_i(t_rtw_i),
        .cs_n_o(cs_n_o), .ras_n_o(ras_n_o), .cas_n_o(cas_n_o), .we_n_o(we_n_o),
        .ba_o(ba_o), .addr_o(addr_o)
`ifdef SAL_SCHED_STATS_EN
        , .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o), .act_cnt_o(act_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [RAW-1:0] ra_of(input int b);
        return 14'h2000 + 14'(b) * 14'h0123;
    endfunction

    function automatic logic [CAW-1:0] ca_of(input int b);
        return 10'h155 + 10'(b) * 10'h04A;
    endfunction

    function automatic vec_t mk(input logic [3:0] a, r, w, p, f,
                                input logic [3:0] ea, er, ew, ep, ef);
        vec_t v;
        v.act = a;    v.rd = r;    v.wr = w;    v.pre = p;    v.rf = f;
        v.e_act = ea; v.e_rd = er; v.e_wr = ew; v.e_pre = ep; v.e_rf = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Pop the bus expectation from the previous cycle, drive this cycle, check grants.
    task automatic cycle(input logic rst, input vec_t v, input string name);
        logic [19:0] e;
        logic [3:0] ctl;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, "_bus"}, 32'({cs_n_o, ras_n_o, cas_n_o, we_n_o, ba_o, addr_o}),
                32'(e));
        end
        rst_n = rst;
        act_req_i = v.act; rd_req_i = v.rd; wr_req_i = v.wr;
        pre_req_i = v.pre; ref_req_i = v.rf;
        #1;
        chk({name, "_gnt"},
            32'({act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o}),
            32'({v.e_act, v.e_rd, v.e_wr, v.e_pre, v.e_rf}));
        if (!rst) begin
            m_ba = 2'd0;
            m_addr = '0;
            ctl = 4'b1111;
        end else begin
            ctl = 4'b0111;
            for (int b = 0; b < NB; b++) begin
                if (v.e_act[b]) begin
                    ctl = 4'b0011; m_ba = 2'(b); m_addr = AW'(ra_of(b));
                end
                if (v.e_rd[b]) begin
                    ctl = 4'b0101; m_ba = 2'(b); m_addr = AW'(ca_of(b)); m_addr[10] = 1'b0;
                end
                if (v.e_wr[b]) begin
                    ctl = 4'b0100; m_ba = 2'(b); m_addr = AW'(ca_of(b)); m_addr[10] = 1'b0;
                end
                if (v.e_pre[b]) begin
                    ctl = 4'b0010; m_ba = 2'(b); m_addr = '0;
                end
                if (v.e_rf[b]) begin
                    ctl = 4'b0001; m_ba = 2'(b); m_addr = '0;
                end
            end
        end
        sb.push_back({ctl, m_ba, m_addr});
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        act_req_i = '0; rd_req_i = '0; wr_req_i = '0; pre_req_i = '0; ref_req_i = '0;
        t_rrd_i = 4'd1; t_ccd_i = 4'd1; t_wtr_i = 4'd1; t_rtw_i = 4'd1;
        for (int b = 0; b < NB; b++) begin
            ra_i[b*RAW +: RAW] = ra_of(b);
            ca_i[b*CAW +: CAW] = ca_of(b);
        end

        //              act   rd    wr    pre   ref   e_act e_rd  e_wr  e_pre e_ref
        tbl[0]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tbl[1]  = mk(4'h4, 4'h1, 4'h0, 4'h2, 4'h8, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
        tbl[2]  = mk(4'h4, 4'h0, 4'h0, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0);
        tbl[3]  = mk(4'h4, 4'h0, 4'h0, 4'h0, 4'h8, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        tbl[4]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8);
        tbl[5]  = mk(4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
        tbl[6]  = mk(4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
        tbl[7]  = mk(4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
        tbl[8]  = mk(4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0);
        tbl[9]  = mk(4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
        tbl[10] = mk(4'h1, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
        tbl[11] = mk(4'h0, 4'h8, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0);
        tbl[12] = mk(4'h0, 4'h8, 4'h4, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0);
        tbl[13] = mk(4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
        tbl[14] = mk(4'h0, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0);
        tbl[15] = mk(4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        tbl[16] = mk(4'h2, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);

        // Requests present during reset must not be granted.
        cycle(1'b0, mk(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0, 0, 0, 0), "reset0");
        cycle(1'b0, mk(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0, 0, 0, 0), "reset1");
        for (int i = 0; i < 17; i++) cycle(1'b1, tbl[i], $sformatf("vec%0d", i));

        // tRRD=4: bank0 ACT, bank2 ACT four cycles later.
        cycle(1'b0, idle, "rrd_rst");
        t_rrd_i = 4'd4;
        cycle(1'b1, mk(4'h5, 0, 0, 0, 0, 4'h1, 0, 0, 0, 0), "rrd_c0");
        for (int k = 1; k < 4; k++)
            cycle(1'b1, mk(4'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("rrd_c%0d", k));
        cycle(1'b1, mk(4'h4, 0, 0, 0, 0, 4'h4, 0, 0, 0, 0), "rrd_c4");
        t_rrd_i = 4'd1;
        cycle(1'b1, idle, "rrd_idle");

        // WR on bank1 then RD on bank3 held: tWTR=6 dominates tCCD=2.
        t_wtr_i = 4'd6; t_ccd_i = 4'd2;
        cycle(1'b1, mk(0, 0, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0), "wtr_c0");
        for (int k = 1; k < 6; k++)
            cycle(1'b1, mk(0, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("wtr_c%0d", k));
        cycle(1'b1, mk(0, 4'h8, 0, 0, 0, 0, 4'h8, 0, 0, 0), "wtr_c6");
        t_wtr_i = 4'd1; t_ccd_i = 4'd1;
        cycle(1'b1, idle, "wtr_idle");

        // Reset in the middle of a tRRD=8 window clears it.
        t_rrd_i = 4'd8;
        cycle(1'b1, mk(4'h2, 0, 0, 0, 0, 4'h2, 0, 0, 0, 0), "mid_c0");
        cycle(1'b1, mk(4'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mid_c1");
        cycle(1'b0, mk(4'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mid_c2");
        cycle(1'b1, mk(4'h8, 0, 0, 0, 0, 4'h8, 0, 0, 0, 0), "mid_c3");
        t_rrd_i = 4'd1;
        cycle(1'b1, idle, "mid_idle");

`ifdef SAL_SCHED_STATS_EN
        cycle(1'b0, idle, "st_rst");
        cycle(1'b1, mk(0, 4'h1, 0, 0, 0, 0, 4'h1, 0, 0, 0), "st_rd0");
        cycle(1'b1, mk(0, 4'h2, 0, 0, 0, 0, 4'h2, 0, 0, 0), "st_rd1");
        cycle(1'b1, mk(0, 4'h4, 0, 0, 0, 0, 4'h4, 0, 0, 0), "st_rd2");
        cycle(1'b1, mk(0, 0, 4'h8, 0, 0, 0, 0, 4'h8, 0, 0), "st_wr3");
        cycle(1'b1, mk(0, 0, 4'h1, 0, 0, 0, 0, 4'h1, 0, 0), "st_wr0");
        cycle(1'b1, idle, "st_idle");
        chk("rd_cnt", rd_cnt_o, 32'd3);
        chk("wr_cnt", wr_cnt_o, 32'd2);
        chk("act_cnt", act_cnt_o, 32'd0);
`endif

        // Drain the last bus expectation.
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            chk("drain_bus", 32'({cs_n_o, ras_n_o, cas_n_o, we_n_o, ba_o, addr_o}),
                32'(sb.pop_front()));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
